// File: rtl/pwm_fade_ctrl_pkg.sv
// ============================================================================
// Module   : pwm_pkg
// Purpose  : Shared constants and FSM encoding for the PWM fade controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    localparam int          DUTY_W_DFLT = 8;
    localparam int unsigned DUTY_MAX    = (1 << DUTY_W_DFLT) - 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } fsm_state_t;

endpackage

`default_nettype wire

// File: rtl/pwm_fade_ctrl_if.sv
// ============================================================================
// Module   : pwm_fade_ctrl_if
// Purpose  : Target-duty request channel (valid/ready) into the fade controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pwm_fade_ctrl_if
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DFLT,
    parameter int RATE_W = 16
);
    logic [DUTY_W-1:0] tgt_duty;
    logic [RATE_W-1:0] tgt_rate;
    logic              tgt_valid;
    logic              tgt_ready;

    modport master (
        output tgt_duty,
        output tgt_rate,
        output tgt_valid,
        input  tgt_ready
    );

    modport slave (
        input  tgt_duty,
        input  tgt_rate,
        input  tgt_valid,
        output tgt_ready
    );
endinterface

`default_nettype wire

// File: rtl/pwm_fade_ctrl_core.sv
// ============================================================================
// Module   : pwm_core
// Purpose  : Period counter, shadow duty register and registered comparator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_core
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_nxt,
    output logic              period_end,
    output logic [DUTY_W-1:0] duty_o,
    output logic              pwm_o
);

    logic [DUTY_W-1:0] r_cnt;
    logic [DUTY_W-1:0] r_duty;
    logic              r_pwm;
    logic              w_cmp;

    assign period_end = (&r_cnt) & enable;
    assign duty_o     = r_duty;
    assign pwm_o      = r_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Duty is only shadow-loaded at the wrap so a period is never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty <= '0;
        end else if (period_end) begin
            r_duty <= duty_nxt;
        end
    end

    // Full scale needs its own case: cnt < MAX would drop the last clock.
    always_comb begin
        w_cmp = 1'b0;
        if (r_duty == '0) begin
            w_cmp = 1'b0;
        end else if (&r_duty) begin
            w_cmp = 1'b1;
        end else begin
            w_cmp = (r_cnt < r_duty);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= enable & w_cmp;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pwm_fade_ctrl.sv
// ============================================================================
// Module   : pwm_fade_ctrl
// Purpose  : Ramps the applied PWM duty one LSB at a time toward a requested
//            target, stepping every (rate+1) PWM periods.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_fade_ctrl
    import pwm_pkg::*;
#(
    parameter int DUTY_W = DUTY_W_DFLT,
    parameter int RATE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    pwm_fade_ctrl_if.slave     tgt,
    output logic [DUTY_W-1:0]  duty_o,
    output logic               busy,
    output logic               done,
    output logic               pwm_o,
    output logic               led_o
);

    fsm_state_t        r_state;
    logic [DUTY_W-1:0] r_target;
    logic [DUTY_W-1:0] r_cur;
    logic [RATE_W-1:0] r_rate;
    logic [RATE_W-1:0] r_timer;
    logic              r_busy;
    logic              r_done;

    logic              w_period_end;
    logic              w_accept;
    logic              w_step;
    logic [DUTY_W-1:0] w_cur_nxt;
    logic              w_pwm;

    assign tgt.tgt_ready = enable & (r_state == ST_IDLE);
    assign w_accept      = tgt.tgt_valid & tgt.tgt_ready;

    assign busy  = r_busy;
    assign done  = r_done;
    assign pwm_o = w_pwm;
    assign led_o = w_pwm;

    assign w_step = (r_state == ST_RAMP) & w_period_end &
                    (r_timer == r_rate) & (r_cur != r_target);

    // Stepping only toward an in-range target keeps cur inside 0..MAX.
    always_comb begin
        w_cur_nxt = r_cur;
        if (w_step) begin
            if (r_target > r_cur) begin
                w_cur_nxt = r_cur + 1'b1;
            end else begin
                w_cur_nxt = r_cur - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_target <= '0;
            r_cur    <= '0;
            r_rate   <= '0;
            r_timer  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (enable) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_target <= tgt.tgt_duty;
                            r_rate   <= tgt.tgt_rate;
                            r_timer  <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= ST_RAMP;
                        end
                    end
                    ST_RAMP: begin
                        if (w_period_end) begin
                            if (r_timer == r_rate) begin
                                r_timer <= '0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                        r_cur <= w_cur_nxt;
                        // Also covers a request equal to the current duty.
                        if (w_cur_nxt == r_target) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    pwm_core #(
        .DUTY_W (DUTY_W)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .duty_nxt   (w_cur_nxt),
        .period_end (w_period_end),
        .duty_o     (duty_o),
        .pwm_o      (w_pwm)
    );

endmodule

`default_nettype wire

// File: tb/tb_pwm_fade_ctrl.sv
// ============================================================================
// Module   : tb_pwm_fade_ctrl
// Purpose  : Directed self-checking bench for pwm_fade_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_fade_ctrl;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable;
    logic [7:0] duty_o;
    logic       busy;
    logic       done;
    logic       pwm_o;
    logic       led_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pwm_fade_ctrl_if #(.DUTY_W(8), .RATE_W(16)) tgt_if ();

    pwm_fade_ctrl #(.DUTY_W(8), .RATE_W(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tgt    (tgt_if.slave),
        .duty_o (duty_o),
        .busy   (busy),
        .done   (done),
        .pwm_o  (pwm_o),
        .led_o  (led_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference period counter and count of enabled period ends.
    logic [7:0] m_cnt;
    int         pe_cnt = 0;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 8'd0;
        end else if (enable) begin
            if (m_cnt == 8'hFF) pe_cnt <= pe_cnt + 1;
            m_cnt <= m_cnt + 8'd1;
        end
    end

    // Applied duty may only change on the cycle where the counter is 0.
    logic [7:0] prev_duty = 8'd0;
    int         duty_chg  = 0;
    always @(negedge clk) begin
        if (rst_n && (duty_o !== prev_duty)) begin
            chk("glitch_cnt", {24'd0, m_cnt}, 32'd0);
            duty_chg++;
        end
        prev_duty = duty_o;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [7:0] d, input logic [15:0] r, output int pe0);
        tgt_if.tgt_duty  = d;
        tgt_if.tgt_rate  = r;
        tgt_if.tgt_valid = 1'b1;
        for (int i = 0; i < 2000 && !tgt_if.tgt_ready; i++) tick(1);
        chk("req_ready", tgt_if.tgt_ready, 1);
        tick(1);
        tgt_if.tgt_valid = 1'b0;
        pe0 = pe_cnt;
        chk("busy_after_accept", busy, 1);
    endtask

    task automatic finish_ramp(input string tag, input logic [7:0] tgt, input int pe0,
                               input int c0, input int exp_per, input int exp_steps);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < exp_per * 256 + 1000; i++) begin
            tick(1);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1);
        chk({tag, "_periods"}, pe_cnt - pe0, exp_per);
        chk({tag, "_duty"}, duty_o, tgt);
        chk({tag, "_done_at_cnt0"}, m_cnt, 0);
        chk({tag, "_busy_clr"}, busy, 0);
        tick(1);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_steps"}, duty_chg - c0, exp_steps);
    endtask

    task automatic count_high(input string tag, input int exp);
        int np, nl;
        np = 0;
        nl = 0;
        tick(256);
        repeat (256) begin
            tick(1);
            np += int'(pwm_o);
            nl += int'(led_o);
        end
        chk({tag, "_pwm_high"}, np, exp);
        chk({tag, "_led_high"}, nl, exp);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_duty"}, duty_o, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pwm"}, pwm_o, 0);
        chk({tag, "_led"}, led_o, 0);
        chk({tag, "_ready"}, tgt_if.tgt_ready, 1);
    endtask

    initial begin
        int  pe0, c0, np;
        logic [7:0] d_hold;

        enable           = 1'b1;
        tgt_if.tgt_valid = 1'b0;
        tgt_if.tgt_duty  = 8'd0;
        tgt_if.tgt_rate  = 16'd0;

        // Reset and idle
        tick(2);
        check_reset_state("rst");
        rst_n = 1'b1;
        np = 0;
        repeat (1024) begin
            tick(1);
            np += int'(pwm_o);
        end
        chk("idle_pwm_high", np, 0);
        check_reset_state("idle");

        // Request equal to current duty: done two cycles after acceptance
        send_req(8'd0, 16'd0, pe0);
        chk("eq_done_early", done, 0);
        tick(1);
        chk("eq_done", done, 1);
        chk("eq_busy", busy, 0);
        chk("eq_duty", duty_o, 0);
        tick(1);
        chk("eq_done_pulse", done, 0);

        // 0 -> 64 at rate 0
        send_req(8'd64, 16'd0, pe0);
        c0 = duty_chg;
        finish_ramp("up64", 8'd64, pe0, c0, 64, 64);
        count_high("d64", 64);

        // 64 -> 255 at rate 0
        send_req(8'd255, 16'd0, pe0);
        c0 = duty_chg;
        finish_ramp("up255", 8'd255, pe0, c0, 191, 191);
        count_high("d255", 256);

        // Ramp down toward 20, then asynchronous reset mid-ramp
        send_req(8'd20, 16'd0, pe0);
        tick(1000);
        chk("down_duty", duty_o, 255 - (pe_cnt - pe0));
        chk("down_busy", busy, 1);
        rst_n = 1'b0;
        #2;
        check_reset_state("async_rst");
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        tick(2);
        check_reset_state("post_rst");

        // 0 -> 5 at rate 3, with requests ignored during the ramp
        send_req(8'd5, 16'd3, pe0);
        c0 = duty_chg;
        tgt_if.tgt_duty  = 8'd200;
        tgt_if.tgt_rate  = 16'd0;
        tgt_if.tgt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("ramp_ready_low", tgt_if.tgt_ready, 0);
        end
        tgt_if.tgt_valid = 1'b0;
        finish_ramp("rate3", 8'd5, pe0, c0, 20, 5);

        // 5 -> 0 at rate 0
        send_req(8'd0, 16'd0, pe0);
        c0 = duty_chg;
        finish_ramp("down0", 8'd0, pe0, c0, 5, 5);
        count_high("d0", 0);

        // 0 -> 6 with enable dropped for 500 cycles mid-ramp
        send_req(8'd6, 16'd0, pe0);
        c0 = duty_chg;
        tick(600);
        d_hold = duty_o;
        chk("hold_duty_before", d_hold, pe_cnt - pe0);
        enable = 1'b0;
        tick(500);
        chk("hold_pwm", pwm_o, 0);
        chk("hold_led", led_o, 0);
        chk("hold_duty", duty_o, d_hold);
        chk("hold_busy", busy, 1);
        chk("hold_ready", tgt_if.tgt_ready, 0);
        enable = 1'b1;
        finish_ramp("resume", 8'd6, pe0, c0, 6, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
